// File: rtl/npu_host_pkg.sv
// npu_host_pkg: shared state encoding and header layout
// for the NPU host sequencer.
package npu_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WGT,
    S_IN,
    S_WAIT,
    S_OUT,
    S_DRAIN
  } state_t;

  // header word offsets: L, then count fields, then act
  localparam int HDR_L    = 0;
  localparam int HDR_CNT0 = 1;

  function automatic int hdr_act_ofs(input int ml);
    return ml + 2;
  endfunction

  function automatic int hdr_words(input int ml);
    return ml + 3;
  endfunction

endpackage

// File: rtl/npu_skid_buf2.sv
// npu_skid_buf2: 2-entry FIFO carrying the result stream.
// Ports: i_push/i_data write side, i_pop read-ready,
// o_valid/o_data head entry, o_occ occupancy (0..2).
module npu_skid_buf2 #(
  parameter int W = 33
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_occ;
  logic         w_pop;

  assign w_pop   = i_pop && (r_occ != 2'd0);
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_mem[r_rp];
  assign o_occ   = r_occ;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      if (i_push && !w_pop) begin
        r_occ <= r_occ + 2'd1;
      end else if (!i_push && w_pop) begin
        r_occ <= r_occ - 2'd1;
      end
    end
  end

endmodule

// File: rtl/npu_host_seq.sv
// npu_host_seq: host-side sequencer for the NPU word-serial
// load / compute / readout protocol.
// Ports: start/reuse_cfg/num_batches command; s_* host words
// in; m_* results out (m_last ends a vector); npu_we/wdata
// writes, npu_oe/rdata reads, npu_ready result flag; busy,
// done, cfg_valid, err_timeout status. rst is async active-low.
module npu_host_seq
  import npu_host_pkg::*;
#(
  parameter int DW         = 32,
  parameter int MAX_LAYERS = 3,
  parameter int NW         = 6,
  parameter int BW         = 8,
  parameter int TO_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          reuse_cfg,
  input  logic [BW-1:0] num_batches,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          npu_we,
  output logic [DW-1:0] npu_wdata,
  output logic          npu_oe,
  input  logic [DW-1:0] npu_rdata,
  input  logic          npu_ready,
  output logic          busy,
  output logic          done,
  output logic          cfg_valid,
  output logic          err_timeout
);

  localparam int NF    = MAX_LAYERS + 1;
  localparam int LW    = $clog2(MAX_LAYERS + 1);
  localparam int HN    = hdr_words(MAX_LAYERS);
  localparam int HCW   = $clog2(HN);
  localparam int HLAST = hdr_act_ofs(MAX_LAYERS);

  state_t r_state;
  state_t w_state_nx;

  logic [HCW-1:0]  r_hcnt;
  logic [LW-1:0]   r_l;
  logic [LW-1:0]   r_lyr;
  logic [NW-1:0]   r_cnt [NF];
  logic [NW-1:0]   r_nrn;
  logic [NW:0]     r_wrd;
  logic [NW-1:0]   r_icnt;
  logic [NW-1:0]   r_iss;
  logic            r_iss_done;
  logic [BW-1:0]   r_bat;
  logic [TO_W-1:0] r_to;
  logic            r_cfg;
  logic            r_err;
  logic            r_inf;
  logic            r_inf_last;

  logic            w_hs;
  logic            w_start_ok;
  logic            w_hdr_last;
  logic [LW-1:0]   w_l_sat;
  logic [LW-1:0]   w_lyr_nx;
  logic [NW-1:0]   w_src;
  logic [NW-1:0]   w_dst;
  logic            w_bias;
  logic            w_wgt_last;
  logic            w_in_last;
  logic            w_to_exp;
  logic            w_cap_last;
  logic [1:0]      w_occ;
  logic [2:0]      w_pend;
  logic            w_oe;

  assign w_hs       = s_valid && s_ready;
  assign npu_we     = w_hs;
  assign npu_wdata  = w_hs ? s_data : '0;

  assign w_start_ok = (r_state == S_IDLE) && start &&
                      (!reuse_cfg || r_cfg);
  assign w_hdr_last = (r_hcnt == HCW'(HLAST));
  assign w_l_sat    = (s_data >= DW'(MAX_LAYERS)) ?
                      LW'(MAX_LAYERS - 1) : s_data[LW-1:0];

  // source width is the current layer's count; destination is
  // the next field, except the last active layer feeds "out"
  assign w_lyr_nx   = r_lyr + LW'(1);
  assign w_src      = r_cnt[r_lyr];
  assign w_dst      = (r_lyr == r_l) ? r_cnt[NF-1] :
                      r_cnt[w_lyr_nx];
  assign w_bias     = (r_wrd == ({1'b0, w_src} +
                      {{NW{1'b0}}, 1'b1}));
  assign w_wgt_last = w_bias && (r_nrn == w_dst) &&
                      (r_lyr == r_l);

  assign w_in_last  = (r_icnt == r_cnt[0]);
  assign w_to_exp   = &r_to;
  assign w_cap_last = r_inf && r_inf_last;

  // buffered plus in-flight words must fit the 2-entry buffer
  assign w_pend     = {1'b0, w_occ} + {2'b00, r_inf};
  assign w_oe       = (r_state == S_OUT) && !r_iss_done &&
                      (w_pend < 3'd2);

  assign cfg_valid   = r_cfg;
  assign err_timeout = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    s_ready    = 1'b0;
    npu_oe     = 1'b0;
    busy       = (r_state != S_IDLE);
    done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !reuse_cfg) begin
          w_state_nx = S_HDR;
        end else if (start && r_cfg) begin
          w_state_nx = S_IN;
        end
      end
      S_HDR: begin
        s_ready = 1'b1;
        if (w_hs && w_hdr_last) w_state_nx = S_WGT;
      end
      S_WGT: begin
        s_ready = 1'b1;
        if (w_hs && w_wgt_last) w_state_nx = S_IN;
      end
      S_IN: begin
        s_ready = 1'b1;
        if (w_hs && w_in_last) w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (npu_ready) begin
          w_state_nx = S_OUT;
        end else if (w_to_exp) begin
          w_state_nx = S_IDLE;
        end
      end
      S_OUT: begin
        npu_oe = w_oe;
        if (w_cap_last) begin
          w_state_nx = (r_bat != '0) ? S_IN : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_occ == 2'd0) begin
          done       = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcnt     <= '0;
      r_l        <= '0;
      r_lyr      <= '0;
      for (int i = 0; i < NF; i++) r_cnt[i] <= '0;
      r_nrn      <= '0;
      r_wrd      <= '0;
      r_icnt     <= '0;
      r_iss      <= '0;
      r_iss_done <= 1'b0;
      r_bat      <= '0;
      r_to       <= '0;
      r_cfg      <= 1'b0;
      r_err      <= 1'b0;
      r_inf      <= 1'b0;
      r_inf_last <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_bat  <= num_batches;
        r_err  <= 1'b0;
        r_hcnt <= '0;
      end

      if ((r_state == S_HDR) && w_hs) begin
        r_hcnt <= r_hcnt + HCW'(1);
        if (r_hcnt == HCW'(HDR_L)) r_l <= w_l_sat;
        for (int i = 0; i < NF; i++) begin
          if (r_hcnt == HCW'(HDR_CNT0 + i)) begin
            r_cnt[i] <= s_data[NW-1:0];
          end
        end
        if (w_hdr_last) begin
          r_lyr <= '0;
          r_nrn <= '0;
          r_wrd <= '0;
        end
      end

      if ((r_state == S_WGT) && w_hs) begin
        if (!w_bias) begin
          r_wrd <= r_wrd + (NW+1)'(1);
        end else begin
          r_wrd <= '0;
          if (r_nrn != w_dst) begin
            r_nrn <= r_nrn + NW'(1);
          end else begin
            r_nrn <= '0;
            if (r_lyr != r_l) begin
              r_lyr <= w_lyr_nx;
            end else begin
              r_cfg <= 1'b1;
            end
          end
        end
      end

      if ((r_state == S_IN) && w_hs) begin
        r_icnt <= w_in_last ? '0 : r_icnt + NW'(1);
        if (w_in_last) r_to <= '0;
      end

      if (r_state == S_WAIT) begin
        r_to <= r_to + TO_W'(1);
        if (npu_ready) begin
          r_iss      <= '0;
          r_iss_done <= 1'b0;
        end else if (w_to_exp) begin
          r_err <= 1'b1;
        end
      end

      // a read issued now is captured next cycle
      r_inf      <= w_oe;
      r_inf_last <= w_oe && (r_iss == r_cnt[NF-1]);
      if (w_oe) begin
        if (r_iss == r_cnt[NF-1]) begin
          r_iss_done <= 1'b1;
        end else begin
          r_iss <= r_iss + NW'(1);
        end
      end

      if ((r_state == S_OUT) && w_cap_last &&
          (r_bat != '0)) begin
        r_bat <= r_bat - BW'(1);
      end
    end
  end

  npu_skid_buf2 #(
    .W (DW + 1)
  ) u_buf (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (r_inf),
    .i_data  ({r_inf_last, npu_rdata}),
    .i_pop   (m_ready),
    .o_valid (m_valid),
    .o_data  ({m_last, m_data}),
    .o_occ   (w_occ)
  );

endmodule

// File: tb/tb_npu_host_seq.sv
// tb_npu_host_seq: directed bench for npu_host_seq with a
// small NPU model (delayed ready, queued read data).
module tb_npu_host_seq;

  localparam int DW   = 32;
  localparam int ML   = 3;
  localparam int NW   = 6;
  localparam int BW   = 8;
  localparam int TO_W = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          reuse_cfg = 1'b0;
  logic [BW-1:0] num_batches = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          npu_we;
  logic [DW-1:0] npu_wdata;
  logic          npu_oe;
  logic [DW-1:0] npu_rdata = '0;
  logic          npu_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          cfg_valid;
  logic          err_timeout;

  always #5 clk = ~clk;

  npu_host_seq #(
    .DW(DW), .MAX_LAYERS(ML), .NW(NW), .BW(BW), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .reuse_cfg(reuse_cfg), .num_batches(num_batches),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .npu_we(npu_we), .npu_wdata(npu_wdata),
    .npu_oe(npu_oe), .npu_rdata(npu_rdata),
    .npu_ready(npu_ready), .busy(busy), .done(done),
    .cfg_valid(cfg_valid), .err_timeout(err_timeout)
  );

  int checks = 0;
  int errors = 0;

  int we_cnt, oe_cnt, done_cnt, last_cnt;
  int since = 0;
  int ready_delay = 15;
  bit ready_en = 1'b1;
  bit armed = 1'b0;
  bit oe_prev = 1'b0;
  logic [DW:0]   mq [$];
  logic [DW-1:0] rq [$];

  // observe at negedge, away from the active edge
  always @(negedge clk) begin
    if (npu_we) begin
      we_cnt++;
      armed = 1'b1;
      since = 0;
    end else if (npu_oe) begin
      oe_cnt++;
      armed = 1'b0;
    end else begin
      since++;
    end
    oe_prev = npu_oe;
    if (done) done_cnt++;
    if (m_valid && m_ready) begin
      mq.push_back({m_last, m_data});
      if (m_last) last_cnt++;
    end
  end

  // NPU model: data the cycle after npu_oe, ready after delay
  always @(posedge clk) begin
    #1;
    if (oe_prev) begin
      npu_rdata = (rq.size() != 0) ? rq.pop_front() : 32'hDEADBEEF;
    end
    npu_ready = ready_en && armed && (since >= ready_delay);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    we_cnt   = 0;
    oe_cnt   = 0;
    done_cnt = 0;
    last_cnt = 0;
    mq.delete();
    rq.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_start(input bit reuse,
                             input logic [BW-1:0] nb);
    start       = 1'b1;
    reuse_cfg   = reuse;
    num_batches = nb;
    tick();
    start       = 1'b0;
    reuse_cfg   = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] w);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    s_data  = '0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send: s_ready low 200 cycles for %h", w);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    tick();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s idle: busy=%b after %0d cycles, want 0",
               tag, busy, budget);
    end
  endtask

  task automatic test_reset();
    logic [8:0] st;
    #3;
    st = {busy, done, cfg_valid, err_timeout, s_ready,
          m_valid, m_last, npu_we, npu_oe};
    checks++;
    if (st !== 9'b0) begin
      errors++;
      $display("FAIL reset_in: flags=%b want 000000000", st);
    end
    reset_dut();
    @(negedge clk);
    st = {busy, done, cfg_valid, err_timeout, s_ready,
          m_valid, m_last, npu_we, npu_oe};
    checks++;
    if (st !== 9'b0) begin
      errors++;
      $display("FAIL reset_out: flags=%b want 000000000", st);
    end
    checks++;
    if ({m_data, npu_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: m_data=%h wdata=%h want 0",
               m_data, npu_wdata);
    end
    tick();
  endtask

  task automatic test_single();
    logic [DW:0] got;
    clr();
    rq.push_back(32'h45A00000);
    pulse_start(1'b0, '0);
    repeat (6) send('0);
    send(32'h40000000);
    send(32'h45800000);
    send(32'h44800000);
    @(negedge clk);
    checks++;
    if ({busy, s_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_wait: busy,s_ready=%b want 10",
               {busy, s_ready});
    end
    tick();
    wait_idle(200, "single");
    checks++;
    if (we_cnt !== 9) begin
      errors++;
      $display("FAIL single_we: got %0d want 9", we_cnt);
    end
    checks++;
    if (oe_cnt !== 1) begin
      errors++;
      $display("FAIL single_oe: got %0d want 1", oe_cnt);
    end
    got = (mq.size() != 0) ? mq[0] : '0;
    checks++;
    if (mq.size() !== 1 || got !== {1'b1, 32'h45A00000}) begin
      errors++;
      $display("FAIL single_m: n=%0d word=%h want n=1 word=%h",
               mq.size(), got, {1'b1, 32'h45A00000});
    end
    checks++;
    if ({done_cnt, cfg_valid, err_timeout} !==
        {32'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_status: done=%0d cfg=%b err=%b want 1 1 0",
               done_cnt, cfg_valid, err_timeout);
    end
  endtask

  task automatic test_l_sat();
    reset_dut();
    clr();
    pulse_start(1'b0, '0);
    send(32'd9);
    repeat (5) send('0);
    repeat (5) send(32'h1);
    @(negedge clk);
    checks++;
    if (cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL lsat_5: cfg_valid=%b want 0", cfg_valid);
    end
    tick();
    send(32'h1);
    @(negedge clk);
    checks++;
    if (cfg_valid !== 1'b1) begin
      errors++;
      $display("FAIL lsat_6: cfg_valid=%b want 1", cfg_valid);
    end
    tick();
  endtask

  task automatic test_cfg_count();
    logic [DW:0] exp;
    reset_dut();
    clr();
    pulse_start(1'b0, '0);
    send(32'd2);
    send(32'd2);
    send(32'd1);
    send(32'd3);
    send(32'd1);
    send(32'd7);
    for (int i = 0; i < 29; i++) send(32'h100 + i);
    @(negedge clk);
    checks++;
    if (cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL cfg_29: cfg_valid=%b want 0", cfg_valid);
    end
    tick();
    send(32'h200);
    @(negedge clk);
    checks++;
    if ({cfg_valid, busy, s_ready} !== 3'b111) begin
      errors++;
      $display("FAIL cfg_30: cfg,busy,s_ready=%b want 111",
               {cfg_valid, busy, s_ready});
    end
    checks++;
    if (we_cnt !== 36) begin
      errors++;
      $display("FAIL cfg_we: got %0d want 36", we_cnt);
    end
    tick();
    rq.push_back(32'hA0);
    rq.push_back(32'hA1);
    for (int i = 0; i < 3; i++) send(32'h300 + i);
    wait_idle(200, "cfg");
    checks++;
    if (mq.size() !== 2) begin
      errors++;
      $display("FAIL cfg_n: got %0d words want 2", mq.size());
    end
    for (int i = 0; i < mq.size(); i++) begin
      exp = {(i == 1), 32'hA0 + i};
      checks++;
      if (mq[i] !== exp) begin
        errors++;
        $display("FAIL cfg_word%0d: got %h want %h", i, mq[i], exp);
      end
    end
  endtask

  task automatic test_batches();
    logic [DW:0] exp;
    clr();
    for (int i = 0; i < 8; i++) rq.push_back(32'h1000 + i);
    pulse_start(1'b1, 8'd3);
    for (int i = 0; i < 12; i++) send(32'h500 + i);
    wait_idle(300, "batch");
    checks++;
    if ({we_cnt, oe_cnt, last_cnt, done_cnt} !==
        {32'd12, 32'd8, 32'd4, 32'd1}) begin
      errors++;
      $display("FAIL batch_cnt: we=%0d oe=%0d last=%0d done=%0d want 12 8 4 1",
               we_cnt, oe_cnt, last_cnt, done_cnt);
    end
    checks++;
    if (mq.size() !== 8) begin
      errors++;
      $display("FAIL batch_n: got %0d words want 8", mq.size());
    end
    for (int i = 0; i < mq.size(); i++) begin
      exp = {(i % 2 == 1), 32'h1000 + i};
      checks++;
      if (mq[i] !== exp) begin
        errors++;
        $display("FAIL batch_word%0d: got %h want %h", i, mq[i], exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [DW:0] exp;
    bit seen = 1'b0;
    clr();
    pulse_start(1'b0, '0);
    repeat (4) send('0);
    send(32'd4);
    send('0);
    for (int i = 0; i < 10; i++) send(32'h700 + i);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) rq.push_back(32'hC0 + i);
    send(32'h800);
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (oe_cnt > 0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_start: oe_cnt=%0d want >0", oe_cnt);
    end
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (oe_cnt !== 2 || m_valid !== 1'b1 || mq.size() !== 0) begin
      errors++;
      $display("FAIL stall_hold: oe=%0d mv=%b n=%0d want 2 1 0",
               oe_cnt, m_valid, mq.size());
    end
    tick();
    m_ready = 1'b1;
    wait_idle(200, "stall");
    checks++;
    if (oe_cnt !== 5 || mq.size() !== 5 || done_cnt !== 1) begin
      errors++;
      $display("FAIL stall_end: oe=%0d n=%0d done=%0d want 5 5 1",
               oe_cnt, mq.size(), done_cnt);
    end
    for (int i = 0; i < mq.size(); i++) begin
      exp = {(i == 4), 32'hC0 + i};
      checks++;
      if (mq[i] !== exp) begin
        errors++;
        $display("FAIL stall_word%0d: got %h want %h", i, mq[i], exp);
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit hit = 1'b0;
    clr();
    ready_en = 1'b0;
    pulse_start(1'b1, '0);
    send(32'h900);
    while (n < (1 << TO_W) + 50 && !hit) begin
      tick();
      n++;
      if (err_timeout) hit = 1'b1;
    end
    checks++;
    if (!hit || n !== (1 << TO_W)) begin
      errors++;
      $display("FAIL to_cycles: err at %0d (hit=%b) want %0d",
               n, hit, 1 << TO_W);
    end
    @(negedge clk);
    checks++;
    if ({busy, cfg_valid, err_timeout} !== 3'b011 || oe_cnt !== 0) begin
      errors++;
      $display("FAIL to_state: busy,cfg,err=%b oe=%0d want 011 0",
               {busy, cfg_valid, err_timeout}, oe_cnt);
    end
    tick();
    ready_en = 1'b1;
    rq.push_back(32'hE0);
    pulse_start(1'b1, '0);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: err=%b want 0", err_timeout);
    end
    send(32'h901);
    wait_idle(200, "to_recover");
  endtask

  task automatic test_reset_mid();
    logic [8:0]  st;
    clr();
    pulse_start(1'b0, '0);
    repeat (6) send('0);
    send(32'h11);
    s_valid = 1'b1;
    s_data  = 32'hABCD1234;
    @(negedge clk);
    checks++;
    if (npu_we !== 1'b1 || npu_wdata !== 32'hABCD1234) begin
      errors++;
      $display("FAIL rmid_pre: we=%b wdata=%h want 1 abcd1234",
               npu_we, npu_wdata);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    st = {busy, done, cfg_valid, err_timeout, s_ready,
          m_valid, m_last, npu_we, npu_oe};
    checks++;
    if (st !== 9'b0 || npu_wdata !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL rmid_async: flags=%b wdata=%h m=%h want all 0",
               st, npu_wdata, m_data);
    end
    s_valid = 1'b0;
    s_data  = '0;
    tick();
    rst = 1'b1;
    tick();
    pulse_start(1'b1, '0);
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({busy, s_ready, cfg_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_reuse: busy,s_ready,cfg=%b want 000",
               {busy, s_ready, cfg_valid});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_l_sat();
    test_cfg_count();
    test_batches();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
